// File: rtl/serial_tx_arbiter_pkg.sv
// Shared state encodings for the serial transmitter arbiter.
// db_estado reports these values directly; 7 marks the unreachable encoding.
package serial_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CARREGA  = 3'd1,
    INICIA   = 3'd2,
    ESPERA   = 3'd3,
    CONFIRMA = 3'd4,
    LIBERA   = 3'd5,
    ERRO     = 3'd6
  } estado_t;

  localparam logic [2:0] DB_ESTADO_INVALIDO = 3'd7;

endpackage

// File: rtl/serial_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// to the lowest set request when nothing at or above ptr is pending.
module serial_tx_arbiter_rr_picker #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  logic [IDX_W-1:0] idx_any;
  logic [IDX_W-1:0] idx_up;
  logic             found_up;

  // Scanning downward leaves the lowest matching index in each candidate.
  always_comb begin
    idx_any  = '0;
    idx_up   = '0;
    found_up = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_any = IDX_W'(i);
        if (i >= int'(ptr)) begin
          idx_up   = IDX_W'(i);
          found_up = 1'b1;
        end
      end
    end
  end

  assign winner_idx = found_up ? idx_up : idx_any;
  assign valid      = |req;
  assign winner     = valid ? (N_REQ'(1) << winner_idx) : '0;

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one serial transmitter between N_REQ frame producers: round-robin grant
// held for a whole frame, per-byte start/done handshake, timeout abort.
//
// state    | meaning
// OCIOSO   | idle, picking the next requester
// CARREGA  | latch the granted requester's byte, or abandon if it dropped req
// INICIA   | one-cycle start pulse to the transmitter
// ESPERA   | waiting for transmitter done, timeout counter running
// CONFIRMA | one-cycle byte acknowledge to the owner
// LIBERA   | release grant, advance round-robin pointer
// ERRO     | byte timed out, flag raised, frame dropped
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 7,
  parameter int TIMEOUT = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] dados,
  input  logic [N_REQ-1:0]        ultimo,
  input  logic                    pronto_tx,
  output logic                    partida_tx,
  output logic [DATA_W-1:0]       dado_tx,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic                    ocupado,
  output logic                    erro_timeout,
  output logic [2:0]              db_estado
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  // Counter holds the number of completed ESPERA cycles; abort when the
  // post-increment value would reach TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  estado_t estado, estado_nx;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  g_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic              pick_valid;
  logic              ult_flag;
  logic [CNT_W-1:0]  cnt;
  logic              req_g;
  logic              ult_g;
  logic [DATA_W-1:0] dados_g;

  serial_tx_arbiter_rr_picker #(
    .N_REQ (N_REQ)
  ) u_rr_picker (
    .req        (req),
    .ptr        (ptr),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign req_g = |(req & grant);
  assign ult_g = |(ultimo & grant);

  always_comb begin
    dados_g = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) dados_g = dados[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_nx;
  end

  always_comb begin
    estado_nx = estado;
    case (estado)
      OCIOSO:   if (pick_valid) estado_nx = CARREGA;
      CARREGA:  estado_nx = req_g ? INICIA : LIBERA;
      INICIA:   estado_nx = ESPERA;
      ESPERA: begin
        if (pronto_tx)           estado_nx = CONFIRMA;
        else if (cnt == CNT_FIM) estado_nx = ERRO;
      end
      CONFIRMA: estado_nx = ult_flag ? LIBERA : CARREGA;
      LIBERA:   estado_nx = OCIOSO;
      ERRO:     estado_nx = LIBERA;
      default:  estado_nx = OCIOSO;
    endcase
  end

  always_comb begin
    case (estado)
      OCIOSO, CARREGA, INICIA, ESPERA, CONFIRMA, LIBERA, ERRO: db_estado = estado;
      default: db_estado = DB_ESTADO_INVALIDO;
    endcase
  end

  assign partida_tx = (estado == INICIA);
  assign ack        = (estado == CONFIRMA) ? grant : '0;
  assign ocupado    = (estado != OCIOSO);

  // Grant is loaded from the picker on leaving OCIOSO and dropped on the way
  // into LIBERA (or on recovery from an illegal encoding).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant <= '0;
      g_idx <= '0;
      ptr   <= '0;
    end else begin
      if (estado == OCIOSO && pick_valid) begin
        grant <= pick_oh;
        g_idx <= pick_idx;
      end else if (estado_nx == LIBERA || estado_nx == OCIOSO) begin
        grant <= '0;
      end
      if (estado == LIBERA) ptr <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dado_tx      <= '0;
      ult_flag     <= 1'b0;
      erro_timeout <= 1'b0;
    end else begin
      if (estado == CARREGA && req_g) begin
        dado_tx  <= dados_g;
        ult_flag <= ult_g;
      end
      if (estado_nx == ERRO) erro_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 cnt <= '0;
    else if (estado == CARREGA)                cnt <= '0;
    else if (estado == ESPERA && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares the single serial transmitter (one byte per start/done handshake) between N_REQ frame producers, e.g. the sensor-frame sender and a status/alert sender.
- Grants one requester at a time with round-robin priority and holds the grant for a whole multi-byte frame.
- Sequences each byte: start pulse, wait for the transmitter's done, byte acknowledge to the requester.
- Aborts a byte stuck longer than TIMEOUT cycles and flags the error.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DATA_W, 7, serial byte width in bits
- TIMEOUT, 50000, maximum clock cycles in ESPERA before abort (≥2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  N_REQ  requester i wants to send a frame; must stay high until its last byte is acknowledged
- dados  in  N_REQ*DATA_W  byte offered by requester i, at bits [i*DATA_W +: DATA_W]
- ultimo  in  N_REQ  the offered byte of requester i is the last byte of its frame
- pronto_tx  in  1  transmitter done pulse, one cycle
- partida_tx  out  1  transmitter start pulse, one cycle
- dado_tx  out  DATA_W  byte to the transmitter; latched and stable from CARREGA until the next CARREGA
- grant  out  N_REQ  one-hot, registered; owner of the transmitter
- ack  out  N_REQ  one-cycle pulse; requester i advances to its next byte
- ocupado  out  1  high in every state except OCIOSO
- erro_timeout  out  1  sticky; set on a timeout abort, cleared only by reset
- db_estado  out  3  current state encoding

Behaviour:
- Reset values:
  - state OCIOSO, round-robin pointer 0
  - grant, ack, partida_tx, dado_tx, ocupado, erro_timeout all 0
  - timeout counter 0
- All outputs are registered or Moore-decoded from state. No combinational path from an input to partida_tx or ack.
- States and encodings:
  - OCIOSO=0: if req≠0, select the winner g as the first set bit searching from ptr upward with wrap; set grant=onehot(g); go to CARREGA. Otherwise stay.
  - CARREGA=1: if req[g]=0, abandon the frame and go to LIBERA (no byte sent, no ack). Otherwise latch dado_tx=dados[g], latch ultimo[g] into a flag, clear the timeout counter, go to INICIA.
  - INICIA=2: partida_tx=1 for exactly this cycle; go to ESPERA. A pronto_tx arriving in this cycle is ignored.
  - ESPERA=3: increment the timeout counter. On pronto_tx go to CONFIRMA. Else if the counter reaches TIMEOUT-1, go to ERRO.
  - CONFIRMA=4: ack[g]=1 for exactly this cycle. If the latched ultimo flag is set go to LIBERA, else go to CARREGA.
  - LIBERA=5: grant=0; ptr=(g+1) mod N_REQ; go to OCIOSO.
  - ERRO=6: set erro_timeout; no ack; go to LIBERA. The frame is abandoned; the requester must drop req or restart the frame.
  - Encoding 7 is unreachable; it recovers to OCIOSO with grant cleared and is reported as 7.
- Latency, with req rising while in OCIOSO at edge t:
  - grant at t+1
  - partida_tx at t+2
  - ack one cycle after the pronto_tx cycle
- Minimum cost per byte is 4 cycles plus the transmitter time.
- Round-robin: after any frame (completed, abandoned or timed out) the granted index becomes lowest priority. Simultaneous requests are resolved by the pointer only.
- New requests during a frame are never pre-empting; they are evaluated in the OCIOSO after LIBERA.
- The timeout counter is ceil(log2(TIMEOUT)) bits wide and saturates; it is never read outside ESPERA.
- Reset mid-frame returns immediately to OCIOSO with all outputs at reset values, including grant.

Decomposition:
- Shared package holds the state encodings (OCIOSO..ERRO, 3 bits) and the db_estado error code 7.
- One natural sub-module: rr_picker. It is combinational: inputs req and ptr; outputs a one-hot winner and its index, plus a valid flag. It is instantiated once.
- The FSM, latches and timeout counter stay in serial_tx_arbiter.

Test Plan:
- Single frame: N_REQ=2, req=01, 3 bytes 0x41,0x42,0x43 (ultimo on the third), pronto_tx 5 cycles after each partida -> dado_tx sequence 41,42,43, three partida pulses, three ack[0] pulses, grant returns to 00, db_estado ends at 0.
- Contention: req=11 from reset with 1-byte frames -> requester 0 served first, then 1. Repeat with req=11 -> order 1 then... ptr=0, so 0 then 1 again. With requester 0 alone reasserting immediately -> requester 1 is granted before 0's second frame.
- Timeout: TIMEOUT=10, pronto_tx never asserted -> ERRO reached exactly 10 cycles after INICIA, erro_timeout=1 sticky, no ack, grant cleared, next requester served normally.
- Abandon: req[0] dropped while CARREGA pending between bytes -> no partida_tx, LIBERA, grant 00, ptr=1.
- Spurious done: pronto_tx asserted in the INICIA cycle and again 3 cycles later -> only the second pulse produces ack.
- Reset mid-frame during ESPERA -> all outputs 0 in the same cycle, state 0, erro_timeout 0.
